// File: rtl/garbled_circuit.sv
// Yao garbler: walks a gate netlist held in ROM, garbles it with free-XOR and
// half-gates AND, and streams keys, wire labels, AND tables and the output mask.
module garbled_circuit #(
  parameter int          S       = 10,
  parameter int          K       = 128,
  parameter logic [K-1:0] SEED   = {{(K-1){1'b0}}, 1'b1},
  parameter string       NETLIST = "nl.hex"
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [2:0]   tag,
  output logic [S-1:0] index0,
  output logic [S-1:0] index1,
  output logic [K-1:0] data0,
  output logic [K-1:0] data1
);

  localparam int W     = 2*S + 2;
  localparam int DEPTH = 2**S;
  localparam int AW    = S + 1;

  typedef enum logic [2:0] {IDLE, HDR, KEYS, INLAB, GATES, MASK, DONE} state_t;

  state_t         state;
  logic [W-1:0]   rom [DEPTH+4];
  logic [K-1:0]   ram [DEPTH];

  logic [AW-1:0]  cnt, n_in, n_out, n_gates;
  logic [S-1:0]   and_j;
  logic [K-1:0]   prng, key_r, key_hk, c0_lab, mask;

  function automatic logic [K-1:0] xs(input logic [K-1:0] r);
    logic [K-1:0] t;
    t = r ^ (r << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

  function automatic logic [K-1:0] rotl(input logic [K-1:0] x, input int n);
    return (x << n) | (x >> (K - n));
  endfunction

  function automatic logic [K-1:0] hash(input logic [K-1:0] x, input logic [AW-1:0] j,
                                        input logic [K-1:0] hk);
    return rotl(x, 1) ^ rotl(x, 8) ^ hk ^ K'(j);
  endfunction

  // ROM and label-RAM access
  logic [AW-1:0]  rom_addr;
  logic [W-1:0]   rom_word;
  logic [S-1:0]   fld_hi, fld_lo;
  logic [1:0]     op;
  logic [K-1:0]   a0, b0;

  assign rom_addr = (state == GATES) ? cnt + AW'(4) : cnt;
  assign rom_word = rom[rom_addr];
  assign fld_hi   = rom_word[2*S-1:S];
  assign fld_lo   = rom_word[S-1:0];
  assign op       = rom_word[W-1:2*S];
  assign a0       = ram[fld_lo];
  assign b0       = ram[fld_hi];

  // Half-gates AND and free-XOR for the current gate
  logic [AW-1:0]  j2, j2p1, first_out, shamt;
  logic [K-1:0]   ha, har, hb, hbr, tg, te, c0_and, gate_c0, mask_next;
  logic [S-1:0]   gate_wire;

  assign j2        = {and_j, 1'b0};
  assign j2p1      = {and_j, 1'b1};
  assign ha        = hash(a0, j2, key_hk);
  assign har       = hash(a0 ^ key_r, j2, key_hk);
  assign hb        = hash(b0, j2p1, key_hk);
  assign hbr       = hash(b0 ^ key_r, j2p1, key_hk);
  assign tg        = ha ^ har ^ (b0[0] ? key_r : '0);
  assign te        = hb ^ hbr ^ a0;
  assign c0_and    = ha ^ (a0[0] ? tg : '0) ^ hb ^ (b0[0] ? (te ^ a0) : '0);
  assign gate_c0   = (op == 2'd1) ? c0_and : (a0 ^ b0);
  assign gate_wire = S'(n_in + cnt + AW'(2));
  assign first_out = n_gates - n_out;
  assign shamt     = AW'(K-1) - (cnt - first_out);

  // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    mask_next = mask;
    if (cnt >= first_out) mask_next = mask | (K'(gate_c0[0]) << shamt);
  end

  // Input-label generation, two wires per beat; const-1 costs no PRNG draw
  logic [AW-1:0]  n_lab, cnt1;
  logic           lane0_c1, lane1_c1, lane1_ok;
  logic [K-1:0]   draw_a, draw_b, lab0, lab1, prng_lab;

  assign n_lab    = n_in + AW'(2);
  assign cnt1     = cnt + AW'(1);
  assign lane0_c1 = (cnt  == n_in + AW'(1));
  assign lane1_c1 = (cnt1 == n_in + AW'(1));
  assign lane1_ok = (cnt1 < n_lab);
  assign draw_a   = xs(prng);
  assign draw_b   = xs(draw_a);
  assign lab0     = lane0_c1 ? (c0_lab ^ key_r) : draw_a;
  assign lab1     = lane1_c1 ? (lab0 ^ key_r) : draw_b;

  always_comb begin
    prng_lab = draw_a;
    if (lane0_c1)                  prng_lab = prng;
    else if (lane1_ok && !lane1_c1) prng_lab = draw_b;
  end

  // NOTE: the label RAM has no reset; every entry is written before it is read in a run.
  always_ff @(posedge clk) begin
    if (state == INLAB) begin
      ram[cnt[S-1:0]] <= lab0;
      if (lane1_ok) ram[cnt1[S-1:0]] <= lab1;
    end else if (state == GATES) begin
      ram[gate_wire] <= gate_c0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      prng    <= SEED;
      cnt     <= '0;
      n_in    <= '0;
      n_out   <= '0;
      n_gates <= '0;
      and_j   <= '0;
      key_r   <= '0;
      key_hk  <= '0;
      c0_lab  <= '0;
      mask    <= '0;
      tag     <= 3'b000;
      index0  <= '0;
      index1  <= '0;
      data0   <= '0;
      data1   <= '0;
    end else begin
      tag    <= 3'b000;
      index0 <= '0;
      index1 <= '0;
      data0  <= '0;
      data1  <= '0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= HDR;
            cnt   <= '0;
          end
        end
        HDR: begin
          case (cnt[1:0])
            2'd0:    n_in    <= AW'(fld_hi) + AW'(fld_lo);
            2'd1:    n_in    <= n_in + AW'(fld_hi) + AW'(fld_lo);
            2'd2:    n_out   <= AW'(fld_lo);
            default: n_gates <= AW'(fld_lo);
          endcase
          cnt <= cnt1;
          if (cnt == AW'(3)) state <= KEYS;
        end
        KEYS: begin
          key_r  <= draw_a | K'(1);
          key_hk <= draw_b;
          prng   <= draw_b;
          tag    <= 3'b001;
          data0  <= draw_a | K'(1);
          data1  <= draw_b;
          mask   <= '0;
          and_j  <= '0;
          cnt    <= '0;
          state  <= INLAB;
        end
        INLAB: begin
          prng   <= prng_lab;
          if (cnt == n_in)       c0_lab <= lab0;
          else if (cnt1 == n_in) c0_lab <= lab1;
          tag    <= lane1_ok ? 3'b111 : 3'b101;
          index0 <= cnt[S-1:0];
          data0  <= lab0;
          if (lane1_ok) begin
            index1 <= cnt1[S-1:0];
            data1  <= lab1;
          end
          cnt <= cnt + AW'(2);
          if (cnt + AW'(2) >= n_lab) begin
            cnt   <= '0;
            state <= (n_gates == '0) ? MASK : GATES;
          end
        end
        GATES: begin
          mask <= mask_next;
          if (op == 2'd1) begin
            tag    <= 3'b010;
            index0 <= j2[S-1:0];
            index1 <= j2p1[S-1:0];
            data0  <= tg;
            data1  <= te;
            and_j  <= and_j + S'(1);
          end
          cnt <= cnt1;
          if (cnt1 == n_gates) state <= MASK;
        end
        MASK: begin
          tag   <= 3'b011;
          data0 <= mask;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_garbled_circuit.sv
// Self-checking bench for garbled_circuit: netlist vectors, random netlists
// against a spec-level garbling model, plus reset and restart sequences.
module tb_garbled_circuit;
  localparam int S    = 10;
  localparam int K    = 128;
  localparam int MAXG = 64;
  localparam logic [K-1:0] SEED = 128'h1;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [2:0]   tag;
  logic [S-1:0] index0, index1;
  logic [K-1:0] data0, data1;

  always #5 clk = ~clk;

  garbled_circuit #(.S(S), .K(K), .SEED(SEED), .NETLIST("")) dut (
    .clk(clk), .rst(rst), .start(start), .tag(tag),
    .index0(index0), .index1(index1), .data0(data0), .data1(data1)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]   tag;
    logic [S-1:0] i0, i1;
    logic [K-1:0] d0, d1;
  } beat_t;

  typedef struct {
    int ia, ib, na, nb, nout, ng;
    logic [3:0][1:0]   op;
    logic [3:0][S-1:0] in0, in1;
    int exp_lab_beats, exp_and_beats, exp_last_lab_tag;
  } vec_t;

  beat_t got[$];
  beat_t exp_q[$];
  vec_t  vecs[4];

  int ia, ib, na, nb, nout, ng;
  int g_op[MAXG], g_in0[MAXG], g_in1[MAXG];

  logic [K-1:0] m_r, m_key, m_hk;
  logic [K-1:0] m_lab [2**S];
  logic [K-1:0] m_and_a[$], m_and_b[$], m_and_c[$];

  task automatic check(input string nm, input logic [K-1:0] act, input logic [K-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  function automatic logic [K-1:0] m_xs(input logic [K-1:0] r);
    r = r ^ (r << 13);
    r = r ^ (r >> 7);
    r = r ^ (r << 17);
    return r;
  endfunction

  task automatic draw(output logic [K-1:0] v);
    m_r = m_xs(m_r);
    v = m_r;
  endtask

  function automatic logic [K-1:0] m_hash(input logic [K-1:0] x, input int j);
    return {x[K-2:0], x[K-1]} ^ {x[K-9:0], x[K-1:K-8]} ^ m_hk ^ K'(j);
  endfunction

  task automatic write_rom();
    dut.rom[0] = {2'b00, S'(ia), S'(ib)};
    dut.rom[1] = {2'b00, S'(na), S'(nb)};
    dut.rom[2] = {2'b00, S'(5), S'(nout)};
    dut.rom[3] = {2'b00, S'(7), S'(ng)};
    for (int g = 0; g < ng; g++)
      dut.rom[4+g] = {2'(g_op[g]), S'(g_in1[g]), S'(g_in0[g])};
  endtask

  task automatic load_vec(input int v);
    ia = vecs[v].ia; ib = vecs[v].ib; na = vecs[v].na; nb = vecs[v].nb;
    nout = vecs[v].nout; ng = vecs[v].ng;
    for (int g = 0; g < ng; g++) begin
      g_op[g]  = int'(vecs[v].op[g]);
      g_in0[g] = int'(vecs[v].in0[g]);
      g_in1[g] = int'(vecs[v].in1[g]);
    end
    write_rom();
  endtask

  task automatic random_net();
    int n, rem;
    n   = $urandom_range(1, 6);
    ia  = $urandom_range(0, n);      rem = n - ia;
    ib  = $urandom_range(0, rem);    rem = rem - ib;
    na  = $urandom_range(0, rem);    nb  = rem - na;
    ng  = $urandom_range(1, 20);
    for (int g = 0; g < ng; g++) begin
      g_op[g]  = $urandom_range(0, 3);
      g_in0[g] = $urandom_range(0, n + 1 + g);
      g_in1[g] = $urandom_range(0, n + 1 + g);
    end
    nout = $urandom_range(1, ng);
    write_rom();
  endtask

  // Reference garbling: labels in wire order, tables per AND ordinal.
  task automatic build_expected();
    int n, j;
    logic [K-1:0] v, a, b, c, tg, te, mask;
    exp_q.delete(); m_and_a.delete(); m_and_b.delete(); m_and_c.delete();
    n = ia + ib + na + nb;
    draw(v); m_key = v | K'(1);
    draw(m_hk);
    exp_q.push_back('{3'b001, S'(0), S'(0), m_key, m_hk});
    for (int w = 0; w <= n; w++) begin draw(v); m_lab[w] = v; end
    m_lab[n+1] = m_lab[n] ^ m_key;
    for (int i = 0; i < n + 2; i += 2) begin
      if (i + 1 < n + 2) exp_q.push_back('{3'b111, S'(i), S'(i+1), m_lab[i], m_lab[i+1]});
      else               exp_q.push_back('{3'b101, S'(i), S'(0), m_lab[i], K'(0)});
    end
    j = 0;
    for (int g = 0; g < ng; g++) begin
      a = m_lab[g_in0[g]];
      b = m_lab[g_in1[g]];
      if (g_op[g] == 1) begin
        tg = m_hash(a, 2*j) ^ m_hash(a ^ m_key, 2*j) ^ (b[0] ? m_key : K'(0));
        te = m_hash(b, 2*j+1) ^ m_hash(b ^ m_key, 2*j+1) ^ a;
        c  = m_hash(a, 2*j) ^ (a[0] ? tg : K'(0)) ^ m_hash(b, 2*j+1) ^ (b[0] ? (te ^ a) : K'(0));
        exp_q.push_back('{3'b010, S'(2*j), S'(2*j+1), tg, te});
        m_and_a.push_back(a); m_and_b.push_back(b); m_and_c.push_back(c);
        j++;
      end else begin
        c = a ^ b;
      end
      m_lab[n+2+g] = c;
    end
    mask = '0;
    for (int k = 0; k < nout; k++) mask[K-1-k] = m_lab[n+2+ng-nout+k][0];
    exp_q.push_back('{3'b011, S'(0), S'(0), mask, K'(0)});
  endtask

  task automatic pulse_start(input int len);
    @(negedge clk); start = 1'b1;
    repeat (len) @(negedge clk);
    start = 1'b0;
  endtask

  // Collect every non-idle beat up to the mask beat; poke_at >= 0 pulses start mid-run.
  task automatic capture(input string nm, input int budget, input int poke_at);
    int  cyc;
    bit  done;
    got.delete(); done = 1'b0; cyc = 0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      if (tag != 3'b000) got.push_back('{tag, index0, index1, data0, data1});
      if (tag == 3'b011) done = 1'b1;
      start = (cyc == poke_at);
      cyc++;
    end
    start = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_timeout: no mask beat within %0d cycles", nm, budget);
    end
  endtask

  task automatic compare_stream(input string nm);
    int n;
    check({nm, "_len"}, K'(got.size()), K'(exp_q.size()));
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_tag%0d", nm, i), K'(got[i].tag), K'(exp_q[i].tag));
      case (exp_q[i].tag)
        3'b001: begin
          check($sformatf("%s_R", nm),  got[i].d0, exp_q[i].d0);
          check($sformatf("%s_HK", nm), got[i].d1, exp_q[i].d1);
        end
        3'b111, 3'b101: begin
          check($sformatf("%s_li0_%0d", nm, i), K'(got[i].i0), K'(exp_q[i].i0));
          check($sformatf("%s_ld0_%0d", nm, i), got[i].d0, exp_q[i].d0);
          if (exp_q[i].tag[1]) begin
            check($sformatf("%s_li1_%0d", nm, i), K'(got[i].i1), K'(exp_q[i].i1));
            check($sformatf("%s_ld1_%0d", nm, i), got[i].d1, exp_q[i].d1);
          end
        end
        3'b010: begin
          check($sformatf("%s_ti_%0d", nm, i), K'({got[i].i0, got[i].i1}), K'({exp_q[i].i0, exp_q[i].i1}));
          check($sformatf("%s_TG_%0d", nm, i), got[i].d0, exp_q[i].d0);
          check($sformatf("%s_TE_%0d", nm, i), got[i].d1, exp_q[i].d1);
        end
        default: check($sformatf("%s_mask", nm), got[i].d0, exp_q[i].d0);
      endcase
    end
  endtask

  // Evaluator side: the emitted tables must recover C0 ^ (a&b)*R for every input pair.
  task automatic eval_ands(input string nm);
    int j;
    logic [K-1:0] A, B, wg, we;
    j = 0;
    foreach (got[i]) begin
      if (got[i].tag == 3'b010 && j < m_and_a.size()) begin
        for (int a = 0; a < 2; a++)
          for (int b = 0; b < 2; b++) begin
            A  = m_and_a[j] ^ (a[0] ? m_key : K'(0));
            B  = m_and_b[j] ^ (b[0] ? m_key : K'(0));
            wg = m_hash(A, 2*j) ^ (A[0] ? got[i].d0 : K'(0));
            we = m_hash(B, 2*j+1) ^ (B[0] ? (got[i].d1 ^ A) : K'(0));
            check($sformatf("%s_eval%0d_%0d%0d", nm, j, a, b), wg ^ we,
                  m_and_c[j] ^ ((a & b) != 0 ? m_key : K'(0)));
          end
        j++;
      end
    end
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_tag"},    K'(tag),    K'(0));
    check({nm, "_index0"}, K'(index0), K'(0));
    check({nm, "_index1"}, K'(index1), K'(0));
    check({nm, "_data0"},  data0,      K'(0));
    check({nm, "_data1"},  data1,      K'(0));
  endtask

  task automatic idle_quiet(input string nm, input int cycles);
    int busy;
    busy = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (tag != 3'b000) busy++;
    end
    check(nm, K'(busy), K'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [K-1:0] r_first;
    int lab_beats, and_beats, last_lab;

    //            ia ib na nb out ng  op                     in0                in1           lab and last
    vecs[0] = '{0, 0, 1, 1, 1, 1, {2'd0,2'd0,2'd0,2'd1}, {10'd0,10'd0,10'd0,10'd0}, {10'd0,10'd0,10'd0,10'd1}, 2, 1, 7};
    vecs[1] = '{0, 0, 2, 1, 1, 1, {2'd0,2'd0,2'd0,2'd0}, {10'd0,10'd0,10'd0,10'd0}, {10'd0,10'd0,10'd0,10'd2}, 3, 0, 5};
    vecs[2] = '{1, 0, 0, 1, 2, 4, {2'd1,2'd1,2'd1,2'd1}, {10'd6,10'd5,10'd4,10'd0}, {10'd3,10'd0,10'd1,10'd1}, 2, 4, 7};
    vecs[3] = '{1, 1, 1, 0, 2, 3, {2'd0,2'd3,2'd1,2'd2}, {10'd0,10'd6,10'd5,10'd0}, {10'd0,10'd2,10'd4,10'd1}, 3, 1, 5};

    // Reset held for two cycles with start asserted throughout
    rst = 1'b1; start = 1'b1;
    load_vec(0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0; start = 1'b0;
    m_r = SEED;
    idle_quiet("start_ignored_in_reset", 12);

    // Directed netlist vectors
    for (int v = 0; v < 4; v++) begin
      load_vec(v);
      build_expected();
      pulse_start(1);
      capture($sformatf("vec%0d", v), 400, -1);
      lab_beats = 0; and_beats = 0; last_lab = 0;
      foreach (got[i]) begin
        if (got[i].tag[2]) begin lab_beats++; last_lab = int'(got[i].tag); end
        if (got[i].tag == 3'b010) and_beats++;
      end
      check($sformatf("vec%0d_lab_beats", v), K'(lab_beats), K'(vecs[v].exp_lab_beats));
      check($sformatf("vec%0d_and_beats", v), K'(and_beats), K'(vecs[v].exp_and_beats));
      check($sformatf("vec%0d_last_lab_tag", v), K'(last_lab), K'(vecs[v].exp_last_lab_tag));
      if (got.size() > 0) check($sformatf("vec%0d_R_lsb", v), K'(got[0].d0[0]), K'(1));
      if (v == 0 && got.size() > 2)
        check("vec0_const1_label", got[2].d1, got[2].d0 ^ m_key);
      compare_stream($sformatf("vec%0d", v));
      eval_ands($sformatf("vec%0d", v));
    end

    // Random netlists; the PRNG carries over from one run to the next
    for (int r = 0; r < 6; r++) begin
      random_net();
      build_expected();
      pulse_start(1);
      capture($sformatf("rnd%0d", r), 600, -1);
      compare_stream($sformatf("rnd%0d", r));
      eval_ands($sformatf("rnd%0d", r));
    end

    // Two-cycle start from DONE plus a stray start mid-run: exactly one run
    load_vec(2);
    build_expected();
    pulse_start(2);
    capture("dbl", 400, 8);
    compare_stream("dbl");
    r_first = (got.size() > 0) ? got[0].d0 : K'(0);
    idle_quiet("dbl_no_second_run", 20);
    build_expected();
    pulse_start(1);
    capture("restart", 400, -1);
    compare_stream("restart");
    if (got.size() > 0) check("restart_fresh_R", K'(got[0].d0 != r_first), K'(1));

    // Reset in the middle of GATES, then a run on a different header
    load_vec(2);
    build_expected();
    pulse_start(1);
    begin
      int cyc;
      cyc = 0;
      while (tag != 3'b010 && cyc < 200) begin @(negedge clk); cyc++; end
      check("midrst_reached_gates", K'(tag), K'(3'b010));
    end
    rst = 1'b1;
    #1;
    check_zero("midrst");
    repeat (2) @(negedge clk);
    load_vec(0);
    m_r = SEED;
    rst = 1'b0;
    build_expected();
    pulse_start(1);
    capture("after_rst", 400, -1);
    compare_stream("after_rst");
    eval_ands("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
